dsp_mac_sequencer: RTL and testbench
====================================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the beat-count input len.
REQ-002 SHALL have ports clk  in  1: rising-edge clock, the only clock.
REQ-003 SHALL have port RST  in  1: reset, synchronous and active-high.
REQ-004 SHALL have port start  in  1: begin a dot-product job; sampled only in IDLE.
REQ-005 SHALL have port len  in  LEN_W: number of operand beats for the job, captured on start.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, in_a in 18, in_b in 18: operand stream; a beat transfers when in_valid and in_ready are both high on a clk edge.
REQ-007 SHALL have outputs dsp_A 18 and dsp_B 18: operands to the DSP48A1 slice. The slice has A/B direct, MREG=1, PREG=1, OPMODEREG=1, CARRYOUTREG=1, and CEOPCODE tied high.
REQ-008 SHALL have outputs dsp_OPMODE 8, dsp_CEM 1, dsp_CEP 1, dsp_RSTP 1: slice control outputs.
REQ-009 SHALL have inputs dsp_P 48 and dsp_CARRYOUT 1: slice results.
REQ-010 SHALL have outputs res_valid 1, res_data 48, res_ovf 1, busy 1: job result and status.

Function
REQ-011 SHALL implement states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-012 IDLE SHALL behave as follows: in_ready=0 and busy=0. start=1 with len!=0 goes to CLEAR, captures len, and clears the overflow flag. start=1 with len=0 goes directly to DONE with res_data=0 and res_ovf=0.
REQ-013 CLEAR SHALL last exactly 1 cycle with dsp_RSTP=1, then go to RUN.
REQ-014 RUN SHALL drive in_ready=1 until len beats have been accepted, with dsp_A=in_a, dsp_B=in_b, and dsp_CEM equal to the accept strobe (combinational).
REQ-015 SHALL register dsp_OPMODE and update it only on an accepted beat: 8'h01 (P=M) for the first beat of a job, 8'h09 (P=P+M) for every later beat. dsp_OPMODE SHALL hold its value during in_valid gaps.
REQ-016 SHALL drive dsp_CEP high exactly one cycle after each accepted beat, and low otherwise, so that gaps never re-accumulate.
REQ-017 SHALL sample dsp_CARRYOUT one cycle after each dsp_CEP pulse and OR it into a sticky overflow flag.
REQ-018 SHALL deassert in_ready combinationally in the cycle after the len-th beat is accepted, and go RUN->DRAIN on that accept.
REQ-019 DRAIN SHALL wait until the last CEP pulse has occurred and its carry sample is complete, which is exactly 2 cycles after the last accept, then go to DONE.
REQ-020 DONE SHALL last 1 cycle with res_valid=1, res_data=dsp_P, and res_ovf equal to the sticky flag, then go to IDLE.
REQ-021 Latency from the last accepted beat to res_valid SHALL be exactly 3 cycles with no input gaps.
REQ-022 res_data and res_ovf SHALL hold their values until the next DONE.
REQ-023 busy SHALL be 1 in CLEAR, RUN, DRAIN and DONE.
REQ-024 start SHALL be ignored outside IDLE, including when asserted in DONE.
REQ-025 The beat counter SHALL be LEN_W bits, and len=2^LEN_W-1 SHALL complete without wrap.
REQ-026 Arithmetic SHALL be unsigned: the result equals the low 48 bits of sum(in_a*in_b). res_ovf=1 if any accumulation carried out of bit 47.

Reset
REQ-027 RST=1 on a clk edge SHALL force IDLE and clear the counters, the overflow flag and the CEP pipeline, overriding all other inputs including start.
REQ-028 During reset and in the cycle after reset, all outputs SHALL be: in_ready=0, busy=0, res_valid=0, res_data=0, res_ovf=0, dsp_OPMODE=0, dsp_CEM=0, dsp_CEP=0, dsp_RSTP=1.
REQ-029 RST asserted mid-job (RUN or DRAIN) SHALL abort the job with no res_valid pulse. The next start SHALL produce a result unaffected by the aborted beats.

Verification
REQ-030 Bench SHALL cover: len=4, beats (1,2),(3,4),(5,6),(7,8) back-to-back -> res_data=100, res_ovf=0, res_valid exactly 3 cycles after the 4th accept.
REQ-031 Bench SHALL cover: len=3, beats (10,10),(20,2),(3,3) with a 2-cycle in_valid gap between each -> res_data=149, dsp_CEP pulses exactly 3 times.
REQ-032 Bench SHALL cover: len=0 start -> res_valid one cycle after start, res_data=0, dsp_CEM never high.
REQ-033 Bench SHALL cover: len=255, every beat (18'h3FFFF,18'h3FFFF) -> res_data = low 48 bits of 255*(2^18-1)^2, and res_ovf=1 iff the true sum is at least 2^48 (it is not, so res_ovf=0); then len=2 with dsp_P preloaded to force a carry -> res_ovf=1.
REQ-034 Bench SHALL cover: RST pulsed after 2 of 5 beats, then a new len=2 job with (2,3),(4,5) -> res_data=26, with no res_valid from the aborted job.
REQ-035 Bench SHALL cover: start held high continuously -> back-to-back jobs separated by exactly one IDLE cycle, and start in DONE does not restart the job.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequencer that drives a DSP48A1 slice (MREG=1, PREG=1) through one unsigned
// dot-product job per start and returns the 48-bit result with a sticky carry flag.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CEM,
  output logic             dsp_CEP,
  output logic             dsp_RSTP,
  input  logic [47:0]      dsp_P,
  input  logic             dsp_CARRYOUT,
  output logic             res_valid,
  output logic [47:0]      res_data,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             cep_q;
  logic             carry_pend;
  logic             ovf_q;
  logic [7:0]       opmode_q;
  logic [47:0]      res_data_q;
  logic             res_ovf_q;
  logic             accept;
  logic             last_beat;
  logic             drain_done;

  assign accept     = in_valid && (state_q == RUN);
  assign last_beat  = accept && (beat_cnt == (len_q - LEN_W'(1)));
  // Last product is in P and its carry has been sampled once the CEP pipe is empty.
  assign drain_done = carry_pend && !cep_q;

  always_ff @(posedge clk) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (last_beat) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      len_q      <= '0;
      beat_cnt   <= '0;
      cep_q      <= 1'b0;
      carry_pend <= 1'b0;
      ovf_q      <= 1'b0;
      opmode_q   <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      cep_q      <= accept;
      carry_pend <= cep_q;
      if (carry_pend && dsp_CARRYOUT) ovf_q <= 1'b1;
      if (state_q == IDLE && start) begin
        len_q <= len;
        ovf_q <= 1'b0;
      end
      if (state_q == CLEAR)  beat_cnt <= '0;
      else if (accept)       beat_cnt <= beat_cnt + LEN_W'(1);
      // P=M on the first beat, P=P+M afterwards; held through input gaps.
      if (accept) opmode_q <= (beat_cnt == '0) ? 8'h01 : 8'h09;
      if (state_q == IDLE && start && len == '0) begin
        res_data_q <= '0;
        res_ovf_q  <= 1'b0;
      end else if (state_q == DRAIN && drain_done) begin
        res_data_q <= dsp_P;
        res_ovf_q  <= ovf_q | dsp_CARRYOUT;
      end
    end
  end

  assign in_ready   = (state_q == RUN);
  assign dsp_A      = in_a;
  assign dsp_B      = in_b;
  assign dsp_CEM    = accept;
  assign dsp_CEP    = cep_q;
  assign dsp_OPMODE = opmode_q;
  assign dsp_RSTP   = (state_q == IDLE) || (state_q == CLEAR);
  assign res_valid  = (state_q == DONE);
  assign res_data   = res_data_q;
  assign res_ovf    = res_ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice model
// (M register, P register, registered carry-out) attached to the dsp_* ports.
module tb_dsp_mac_sequencer;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             RST;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a, in_b;
  logic [17:0]      dsp_A, dsp_B;
  logic [7:0]       dsp_OPMODE;
  logic             dsp_CEM, dsp_CEP, dsp_RSTP;
  logic [47:0]      dsp_P;
  logic             dsp_CARRYOUT;
  logic             res_valid;
  logic [47:0]      res_data;
  logic             res_ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .RST(RST), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE),
    .dsp_CEM(dsp_CEM), .dsp_CEP(dsp_CEP), .dsp_RSTP(dsp_RSTP),
    .dsp_P(dsp_P), .dsp_CARRYOUT(dsp_CARRYOUT),
    .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  // Slice model; preload_arm replaces the first P=M result with all ones to force a carry.
  logic [35:0] m_reg = '0;
  logic [47:0] p_reg = '0;
  logic        carry_reg = 1'b0;
  logic        preload_arm = 1'b0;

  always @(posedge clk) begin
    if (dsp_CEM) m_reg <= 36'(dsp_A) * 36'(dsp_B);
    if (dsp_RSTP) begin
      p_reg     <= '0;
      carry_reg <= 1'b0;
    end else if (dsp_CEP) begin
      if (dsp_OPMODE == 8'h01 && preload_arm) begin
        p_reg     <= '1;
        carry_reg <= 1'b0;
      end else if (dsp_OPMODE == 8'h01) begin
        p_reg     <= 48'(m_reg);
        carry_reg <= 1'b0;
      end else if (dsp_OPMODE == 8'h09) begin
        {carry_reg, p_reg} <= {1'b0, p_reg} + 49'(m_reg);
      end
    end
  end

  assign dsp_P        = p_reg;
  assign dsp_CARRYOUT = carry_reg;

  int          cyc = 0;
  int          acc_count, cep_count, cem_count, rv_count;
  int          last_acc_cyc, rv_cyc, start_cyc;
  logic        s_acc, s_rv, s_busy, s_ovf;
  logic [47:0] s_data;
  logic [17:0] beat_a[$];
  logic [17:0] beat_b[$];

  // One clock cycle: sample at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_acc = in_valid && in_ready;
    if (s_acc) begin
      acc_count++;
      last_acc_cyc = cyc;
    end
    if (dsp_CEP) cep_count++;
    if (dsp_CEM) cem_count++;
    s_rv = res_valid;
    if (res_valid) begin
      rv_count++;
      rv_cyc = cyc;
    end
    s_busy = busy;
    s_data = res_data;
    s_ovf  = res_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic add_beat(input logic [17:0] a, input logic [17:0] b);
    beat_a.push_back(a);
    beat_b.push_back(b);
  endtask

  task automatic run_beats(input int gap);
    int waited;
    for (int i = 0; i < beat_a.size(); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick();
        end
      end
      in_a = beat_a[i];
      in_b = beat_b[i];
      in_valid = 1'b1;
      waited = 0;
      tick();
      while (!s_acc && waited < 20) begin
        tick();
        waited++;
      end
      checks++;
      if (!s_acc) begin
        errors++;
        $display("[TB] FAIL beat_accept_timeout: beat %0d not accepted, in_ready=%b required 1", i, in_ready);
        in_valid = 1'b0;
        beat_a.delete();
        beat_b.delete();
        return;
      end
    end
    in_valid = 1'b0;
    beat_a.delete();
    beat_b.delete();
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    tick();
    while (!s_rv && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (!s_rv) begin
      errors++;
      $display("[TB] FAIL %s_result_timeout: res_valid=%b required 1", name, s_rv);
    end
  endtask

  task automatic begin_job(input logic [LEN_W-1:0] l);
    acc_count = 0;
    cep_count = 0;
    cem_count = 0;
    rv_count  = 0;
    len   = l;
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    start = 1'b1;
    len = 8'd4;
    in_valid = 1'b1;
    in_a = 18'd9;
    in_b = 18'd9;
    tick();
    tick();
    checks++;
    if ({in_ready, busy, res_valid, res_ovf, dsp_CEM, dsp_CEP, dsp_RSTP} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b required 0000001", {in_ready, busy, res_valid, res_ovf, dsp_CEM, dsp_CEP, dsp_RSTP});
    end
    checks++;
    if (res_data !== 48'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %0h required 0", res_data);
    end
    checks++;
    if (dsp_OPMODE !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_opmode: got %0h required 00", dsp_OPMODE);
    end
    RST = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, res_valid, res_ovf, dsp_CEM, dsp_CEP, dsp_RSTP} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL post_reset_ctrl: got %b required 0000001", {in_ready, busy, res_valid, res_ovf, dsp_CEM, dsp_CEP, dsp_RSTP});
    end
    checks++;
    if (res_data !== 48'd0 || dsp_OPMODE !== 8'h00) begin
      errors++;
      $display("[TB] FAIL post_reset_data: got data %0h opmode %0h required 0 and 00", res_data, dsp_OPMODE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    add_beat(18'd1, 18'd2);
    add_beat(18'd3, 18'd4);
    add_beat(18'd5, 18'd6);
    add_beat(18'd7, 18'd8);
    begin_job(8'd4);
    run_beats(0);
    in_valid = 1'b1;
    in_a = 18'd100;
    in_b = 18'd100;
    wait_result("b2b");
    in_valid = 1'b0;
    checks++;
    if (s_data !== 48'd100) begin
      errors++;
      $display("[TB] FAIL b2b_data: got %0d required 100", s_data);
    end
    checks++;
    if (s_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ovf: got %b required 0", s_ovf);
    end
    checks++;
    if ((rv_cyc - last_acc_cyc) !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_latency: got %0d required 3", rv_cyc - last_acc_cyc);
    end
    checks++;
    if (acc_count !== 4 || cep_count !== 4) begin
      errors++;
      $display("[TB] FAIL b2b_beats: got accepts %0d cep %0d required 4 and 4", acc_count, cep_count);
    end
    tick();
    checks++;
    if (s_rv !== 1'b0 || s_data !== 48'd100) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got valid %b data %0d required 0 and 100", s_rv, s_data);
    end
  endtask

  task automatic test_gaps();
    add_beat(18'd10, 18'd10);
    add_beat(18'd20, 18'd2);
    add_beat(18'd3, 18'd3);
    begin_job(8'd3);
    run_beats(2);
    wait_result("gaps");
    checks++;
    if (s_data !== 48'd149) begin
      errors++;
      $display("[TB] FAIL gaps_data: got %0d required 149", s_data);
    end
    checks++;
    if (cep_count !== 3) begin
      errors++;
      $display("[TB] FAIL gaps_cep_count: got %0d required 3", cep_count);
    end
  endtask

  task automatic test_zero_len();
    begin_job(8'd0);
    wait_result("zero");
    checks++;
    if (s_data !== 48'd0 || s_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_data: got %0d ovf %b required 0 and 0", s_data, s_ovf);
    end
    checks++;
    if ((rv_cyc - start_cyc) !== 1) begin
      errors++;
      $display("[TB] FAIL zero_latency: got %0d required 1", rv_cyc - start_cyc);
    end
    checks++;
    if (cem_count !== 0) begin
      errors++;
      $display("[TB] FAIL zero_cem: got %0d pulses required 0", cem_count);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 255; i++) add_beat(18'h3FFFF, 18'h3FFFF);
    begin_job(8'd255);
    run_beats(0);
    wait_result("max");
    checks++;
    if (s_data !== 48'd17523332874495) begin
      errors++;
      $display("[TB] FAIL max_data: got %0d required 17523332874495", s_data);
    end
    checks++;
    if (s_ovf !== 1'b0 || acc_count !== 255) begin
      errors++;
      $display("[TB] FAIL max_ovf_beats: got ovf %b accepts %0d required 0 and 255", s_ovf, acc_count);
    end
    checks++;
    if ((rv_cyc - last_acc_cyc) !== 3) begin
      errors++;
      $display("[TB] FAIL max_latency: got %0d required 3", rv_cyc - last_acc_cyc);
    end
  endtask

  task automatic test_overflow();
    preload_arm = 1'b1;
    add_beat(18'd1, 18'd1);
    add_beat(18'd2, 18'd3);
    begin_job(8'd2);
    run_beats(0);
    wait_result("ovf");
    preload_arm = 1'b0;
    checks++;
    if (s_ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_flag: got %b required 1", s_ovf);
    end
    checks++;
    if (s_data !== 48'd5) begin
      errors++;
      $display("[TB] FAIL ovf_data: got %0d required 5", s_data);
    end
  endtask

  task automatic test_abort();
    add_beat(18'd100, 18'd100);
    add_beat(18'd200, 18'd200);
    begin_job(8'd5);
    run_beats(0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (s_busy !== 1'b0 || s_data !== 48'd0 || s_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got busy %b data %0d ovf %b required 0 0 0", s_busy, s_data, s_ovf);
    end
    checks++;
    if (rv_count !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid: got %0d res_valid pulses required 0", rv_count);
    end
    add_beat(18'd2, 18'd3);
    add_beat(18'd4, 18'd5);
    begin_job(8'd2);
    run_beats(0);
    wait_result("abort");
    checks++;
    if (s_data !== 48'd26 || s_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_next_job: got %0d ovf %b required 26 and 0", s_data, s_ovf);
    end
  endtask

  task automatic test_back_to_back_start();
    int rv1;
    acc_count = 0;
    cep_count = 0;
    rv_count  = 0;
    len   = 8'd2;
    start = 1'b1;
    add_beat(18'd2, 18'd3);
    add_beat(18'd4, 18'd5);
    run_beats(0);
    wait_result("held1");
    rv1 = rv_cyc;
    checks++;
    if (s_data !== 48'd26) begin
      errors++;
      $display("[TB] FAIL held1_data: got %0d required 26", s_data);
    end
    tick();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_idle_gap: got busy %b required 0", s_busy);
    end
    tick();
    checks++;
    if (s_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_restart: got busy %b required 1", s_busy);
    end
    add_beat(18'd2, 18'd3);
    add_beat(18'd4, 18'd5);
    run_beats(0);
    wait_result("held2");
    start = 1'b0;
    checks++;
    if (s_data !== 48'd26 || rv_count !== 2) begin
      errors++;
      $display("[TB] FAIL held2_data: got %0d after %0d results required 26 after 2", s_data, rv_count);
    end
    checks++;
    if ((rv_cyc - rv1) !== 7) begin
      errors++;
      $display("[TB] FAIL held_spacing: got %0d cycles required 7", rv_cyc - rv1);
    end
    tick();
    tick();
    checks++;
    if (s_busy !== 1'b0 || rv_count !== 2) begin
      errors++;
      $display("[TB] FAIL held_stop: got busy %b results %0d required 0 and 2", s_busy, rv_count);
    end
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_zero_len();
    test_max_len();
    test_overflow();
    test_abort();
    test_back_to_back_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
